// File: rtl/generador_estado.sv
// Derives the 4-bit estado code from need levels and the sleep flag, with minimum-dwell
// rules in normal mode and a button-stepped walk through every code in test mode.
module generador_estado #(
    parameter int HOLD_CYCLES   = 250000000,
    parameter int DWELL_SECONDS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       botontest,
    input  logic       botonreset,
    input  logic       passsecond,
    input  logic [2:0] salud,
    input  logic [2:0] alimentacion,
    input  logic [2:0] energia,
    input  logic [2:0] entretenimiento,
    input  logic [2:0] higiene,
    input  logic       dormido,
    output logic [3:0] estado,
    output logic       modotest,
    output logic       cambio
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int DW = (DWELL_SECONDS > 0) ? $clog2(DWELL_SECONDS + 1) : 1;
    localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_CYCLES);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_SECONDS);

    typedef enum logic [3:0] {
        FELIZ      = 4'b0000,
        CANSADO    = 4'b0001,
        DORMIDO    = 4'b0010,
        HAMBRIENTO = 4'b0011,
        ENFERMO    = 4'b0100,
        ABURRIDO   = 4'b0101,
        SUCIO      = 4'b0110,
        CRITICO    = 4'b0111,
        MURIENDO   = 4'b1000,
        NEUTRAL    = 4'b1010
    } estado_t;

    typedef enum logic {
        NORMAL = 1'b0,
        TEST   = 1'b1
    } modo_t;

    estado_t       est_q, est_d, cand, sig;
    modo_t         modo_q, modo_d;
    logic [CW-1:0] cnt_test_q, cnt_test_d, cnt_reset_q, cnt_reset_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          armado_q, armado_d;
    logic          prev_test_q, prev_sec_q;
    logic          cambio_q, cambio_d;
    logic          urgente, reset_done, test_done, sec_edge, test_fall;

    // Priority ladder: first matching rule decides the normal-mode candidate.
    always_comb begin
        cand = NEUTRAL;
        if (salud <= 3'd1 || alimentacion <= 3'd1)
            cand = MURIENDO;
        else if (salud <= 3'd2 || alimentacion <= 3'd2 || energia <= 3'd2)
            cand = CRITICO;
        else if (dormido)
            cand = DORMIDO;
        else if (salud <= 3'd4)
            cand = ENFERMO;
        else if (alimentacion <= 3'd4)
            cand = HAMBRIENTO;
        else if (energia <= 3'd4)
            cand = CANSADO;
        else if (higiene <= 3'd4)
            cand = SUCIO;
        else if (entretenimiento <= 3'd4)
            cand = ABURRIDO;
        else if (salud == 3'd7 && alimentacion == 3'd7 && energia == 3'd7 &&
                 entretenimiento == 3'd7 && higiene == 3'd7)
            cand = FELIZ;
    end

    // Test-mode walk skips the unused 1001 code and wraps from neutral back to feliz.
    always_comb begin
        case (est_q)
            MURIENDO: sig = NEUTRAL;
            NEUTRAL:  sig = FELIZ;
            FELIZ, CANSADO, DORMIDO, HAMBRIENTO, ENFERMO, ABURRIDO, SUCIO:
                      sig = estado_t'(est_q + 4'd1);
            CRITICO:  sig = MURIENDO;
            default:  sig = FELIZ;
        endcase
    end

    assign urgente    = (cand == MURIENDO) || (cand == CRITICO);
    assign reset_done = botonreset && (cnt_reset_q == HOLD_MAX);
    assign test_done  = (modo_q == NORMAL) && botontest && (cnt_test_q == HOLD_MAX);
    assign sec_edge   = passsecond && !prev_sec_q;
    assign test_fall  = prev_test_q && !botontest;

    // Reset-hold completion outranks test entry; both outrank stepping and normal updates.
    always_comb begin
        est_d       = est_q;
        modo_d      = modo_q;
        armado_d    = armado_q | ~botontest;
        cnt_reset_d = botonreset ? cnt_reset_q + 1'b1 : '0;
        cnt_test_d  = (modo_q == NORMAL && botontest) ? cnt_test_q + 1'b1 : '0;
        dwell_d     = (sec_edge && dwell_q < DWELL_MAX) ? dwell_q + 1'b1 : dwell_q;
        if (reset_done) begin
            modo_d      = NORMAL;
            est_d       = NEUTRAL;
            dwell_d     = '0;
            cnt_reset_d = '0;
            cnt_test_d  = '0;
        end else if (test_done) begin
            modo_d     = TEST;
            est_d      = FELIZ;
            cnt_test_d = '0;
            armado_d   = 1'b0;
        end else if (modo_q == TEST) begin
            if (test_fall && armado_q)
                est_d = sig;
        end else if (cand != est_q && (urgente || dwell_q >= DWELL_MAX)) begin
            est_d = cand;
        end
        if (est_d != est_q)
            dwell_d = '0;
        cambio_d = (est_d != est_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            est_q       <= NEUTRAL;
            modo_q      <= NORMAL;
            cnt_test_q  <= '0;
            cnt_reset_q <= '0;
            dwell_q     <= '0;
            armado_q    <= 1'b0;
            prev_test_q <= 1'b0;
            prev_sec_q  <= 1'b0;
            cambio_q    <= 1'b0;
        end else begin
            est_q       <= est_d;
            modo_q      <= modo_d;
            cnt_test_q  <= cnt_test_d;
            cnt_reset_q <= cnt_reset_d;
            dwell_q     <= dwell_d;
            armado_q    <= armado_d;
            prev_test_q <= botontest;
            prev_sec_q  <= passsecond;
            cambio_q    <= cambio_d;
        end
    end

    assign estado   = est_q;
    assign modotest = (modo_q == TEST);
    assign cambio   = cambio_q;

endmodule

// File: tb/tb_generador_estado.sv
// Scoreboard bench for generador_estado: stimulus queues expected codes, a monitor
// pops one entry on every cambio pulse; directed checks cover holds and latencies.
module tb_generador_estado;

    logic       clk = 1'b0;
    logic       reset, botontest, botonreset, passsecond, dormido;
    logic [2:0] salud, alimentacion, energia, entretenimiento, higiene;
    logic [3:0] estado;
    logic       modotest, cambio;

    typedef struct packed {
        logic [3:0] est;
        logic       modo;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_exp;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic [3:0] pasos [10];
    logic [3:0] actual_est;

    generador_estado #(.HOLD_CYCLES(10), .DWELL_SECONDS(2)) dut (
        .clk(clk), .reset(reset), .botontest(botontest), .botonreset(botonreset),
        .passsecond(passsecond), .salud(salud), .alimentacion(alimentacion),
        .energia(energia), .entretenimiento(entretenimiento), .higiene(higiene),
        .dormido(dormido), .estado(estado), .modotest(modotest), .cambio(cambio)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e, input logic m, input logic c);
        n_checks++;
        if (estado !== e || modotest !== m || cambio !== c) begin
            n_fails++;
            $display("[TB] FAIL %s: got estado=%b modotest=%b cambio=%b, expected estado=%b modotest=%b cambio=%b",
                     name, estado, modotest, cambio, e, m, c);
        end
    endtask

    task automatic expectChange(input logic [3:0] e, input logic m);
        exp_t x;
        x.est  = e;
        x.modo = m;
        sbq.push_back(x);
    endtask

    task automatic setLevels(input logic [2:0] s, input logic [2:0] a, input logic [2:0] en,
                             input logic [2:0] ent, input logic [2:0] h);
        salud = s; alimentacion = a; energia = en; entretenimiento = ent; higiene = h;
    endtask

    task automatic pulseSecond();
        passsecond = 1'b1;
        applyStimulus(1);
        passsecond = 1'b0;
        applyStimulus(1);
    endtask

    // Monitor: each cambio pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cambio === 1'b1) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    n_fails++;
                    $display("[TB] FAIL unexpected_cambio: got estado=%b modotest=%b, expected no change",
                             estado, modotest);
                end else begin
                    mon_exp = sbq.pop_front();
                    if (estado !== mon_exp.est || modotest !== mon_exp.modo) begin
                        n_fails++;
                        $display("[TB] FAIL scoreboard: got estado=%b modotest=%b, expected estado=%b modotest=%b",
                                 estado, modotest, mon_exp.est, mon_exp.modo);
                    end
                end
            end
        end
    end

    initial begin
        pasos = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                  4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b0000};
        reset = 1'b1; botontest = 1'b0; botonreset = 1'b0; passsecond = 1'b0; dormido = 1'b0;
        setLevels(3'd6, 3'd6, 3'd6, 3'd6, 3'd6);
        applyStimulus(2);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("reset_state", 4'b1010, 1'b0, 1'b0);

        // Non-urgent candidate waits for two second edges; the edge in the deciding cycle does not count.
        higiene = 3'd4;
        applyStimulus(3);
        checkOutput("dwell_hold", 4'b1010, 1'b0, 1'b0);
        pulseSecond();
        checkOutput("dwell_one_edge", 4'b1010, 1'b0, 1'b0);
        passsecond = 1'b1;
        applyStimulus(1);
        checkOutput("dwell_same_cycle_edge", 4'b1010, 1'b0, 1'b0);
        expectChange(4'b0110, 1'b0);
        passsecond = 1'b0;
        applyStimulus(1);
        checkOutput("sucio_after_dwell", 4'b0110, 1'b0, 1'b1);

        reset = 1'b1;
        higiene = 3'd6;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("reset_again", 4'b1010, 1'b0, 1'b0);
        salud = 3'd2;
        expectChange(4'b0111, 1'b0);
        applyStimulus(1);
        checkOutput("critico_urgent", 4'b0111, 1'b0, 1'b1);
        salud = 3'd1;
        expectChange(4'b1000, 1'b0);
        applyStimulus(1);
        checkOutput("muriendo_urgent", 4'b1000, 1'b0, 1'b1);

        salud = 3'd4;
        dormido = 1'b1;
        applyStimulus(2);
        checkOutput("dormido_hold", 4'b1000, 1'b0, 1'b0);
        pulseSecond();
        passsecond = 1'b1;
        applyStimulus(1);
        expectChange(4'b0010, 1'b0);
        passsecond = 1'b0;
        applyStimulus(1);
        checkOutput("dormido_after_dwell", 4'b0010, 1'b0, 1'b1);
        alimentacion = 3'd1;
        expectChange(4'b1000, 1'b0);
        applyStimulus(1);
        checkOutput("muriendo_over_dormido", 4'b1000, 1'b0, 1'b1);

        setLevels(3'd6, 3'd6, 3'd6, 3'd6, 3'd6);
        dormido = 1'b0;
        botontest = 1'b1;
        applyStimulus(10);
        checkOutput("test_entry_not_yet", 4'b1000, 1'b0, 1'b0);
        expectChange(4'b0000, 1'b1);
        applyStimulus(1);
        checkOutput("test_entry", 4'b0000, 1'b1, 1'b1);
        botontest = 1'b0;
        applyStimulus(1);
        checkOutput("entry_release_no_step", 4'b0000, 1'b1, 1'b0);
        applyStimulus(2);

        actual_est = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            botontest = 1'b1;
            applyStimulus(2);
            checkOutput("step_stable_while_pressed", actual_est, 1'b1, 1'b0);
            expectChange(pasos[i], 1'b1);
            botontest = 1'b0;
            applyStimulus(1);
            checkOutput("step_on_release", pasos[i], 1'b1, 1'b1);
            actual_est = pasos[i];
            applyStimulus(1);
        end

        botonreset = 1'b1;
        applyStimulus(10);
        checkOutput("reset_hold_not_yet", 4'b0000, 1'b1, 1'b0);
        expectChange(4'b1010, 1'b0);
        applyStimulus(1);
        checkOutput("reset_hold_done", 4'b1010, 1'b0, 1'b1);
        botonreset = 1'b0;
        applyStimulus(2);

        // Both buttons held together: reset completion suppresses test entry.
        botonreset = 1'b1;
        botontest = 1'b1;
        applyStimulus(11);
        checkOutput("both_buttons", 4'b1010, 1'b0, 1'b0);
        applyStimulus(1);
        checkOutput("both_buttons_after", 4'b1010, 1'b0, 1'b0);
        botonreset = 1'b0;
        botontest = 1'b0;
        applyStimulus(2);

        botontest = 1'b1;
        applyStimulus(7);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("reset_mid_hold", 4'b1010, 1'b0, 1'b0);
        applyStimulus(10);
        checkOutput("rehold_not_yet", 4'b1010, 1'b0, 1'b0);
        expectChange(4'b0000, 1'b1);
        applyStimulus(1);
        checkOutput("rehold_entry", 4'b0000, 1'b1, 1'b1);
        botontest = 1'b0;
        applyStimulus(3);

        while (sbq.size() > 0) begin
            mon_exp = sbq.pop_front();
            n_checks++;
            n_fails++;
            $display("[TB] FAIL missing_cambio: got no pulse, expected estado=%b modotest=%b",
                     mon_exp.est, mon_exp.modo);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
